// File: rtl/mux_fetch_if.sv
// Lookup request / word response bundle between a requester and mux_fetch_ctrl.
// The master drives requests and consumes responses; the slave is the controller.
interface mux_fetch_if #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned TAG_WIDTH  = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic [DATA_WIDTH-1:0] req_line;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [TAG_WIDTH-1:0]  req_tag;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WORD_WIDTH-1:0] rsp_word;
    logic [TAG_WIDTH-1:0]  rsp_tag;
    logic                  rsp_err;

    modport master (
        output req_valid, req_line, req_addr, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_word, rsp_tag, rsp_err
    );

    modport slave (
        input  req_valid, req_line, req_addr, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_word, rsp_tag, rsp_err
    );
endinterface

// File: rtl/mux_fetch_ctrl.sv
// Request-side controller for the pipelined word-select MUX: drives din/addr, tracks the fixed
// MUX latency with a tag pipeline and buffers results in a credit-protected FWFT FIFO.
module mux_fetch_ctrl #(
    parameter int unsigned DATA_WIDTH  = 512,
    parameter int unsigned WORD_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned TAG_WIDTH   = 8,
    parameter int unsigned MUX_LATENCY = 3,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    mux_fetch_if.slave                         bus,
    output logic [DATA_WIDTH-1:0]              mux_din,
    output logic [ADDR_WIDTH-1:0]              mux_addr,
    input  logic [WORD_WIDTH-1:0]              mux_dout,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    inflight
);
    localparam int unsigned NumWords = DATA_WIDTH / WORD_WIDTH;
    localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW     = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH:0] NumWordsC = (ADDR_WIDTH + 1)'(NumWords);
    localparam logic [CntW-1:0]     DepthC    = CntW'(FIFO_DEPTH);

    logic                   accept;
    logic                   pop;
    logic                   push;
    logic                   addr_err;
    logic                   req_ready_q;
    logic [CntW-1:0]        inflight_q, inflight_d;
    logic [CntW-1:0]        count_q, count_d;
    logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [MUX_LATENCY-1:0] pipe_vld_q;
    logic [MUX_LATENCY-1:0] pipe_err_q;
    logic [TAG_WIDTH-1:0]   pipe_tag_q  [MUX_LATENCY];
    logic [WORD_WIDTH-1:0]  fifo_word_q [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0]   fifo_tag_q  [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  fifo_err_q;

    assign bus.req_ready = req_ready_q & ~rst;
    assign accept        = bus.req_valid & bus.req_ready;
    assign addr_err      = {1'b0, bus.req_addr} >= NumWordsC;

    assign mux_din  = bus.req_line;
    assign mux_addr = accept ? bus.req_addr : '0;

    assign push = pipe_vld_q[MUX_LATENCY-1];

    // Gated by rst so nothing stale shows while the synchronous clear is pending.
    assign bus.rsp_valid = ~rst & (count_q != '0);
    assign pop           = bus.rsp_valid & bus.rsp_ready;
    assign bus.rsp_word  = bus.rsp_valid ? fifo_word_q[rd_ptr_q] : '0;
    assign bus.rsp_tag   = bus.rsp_valid ? fifo_tag_q[rd_ptr_q] : '0;
    assign bus.rsp_err   = bus.rsp_valid & fifo_err_q[rd_ptr_q];

    assign inflight = inflight_q;

    always_comb begin
        inflight_d = inflight_q;
        count_d    = count_q;
        if (accept) inflight_d = inflight_d + CntW'(1);
        if (pop)    inflight_d = inflight_d - CntW'(1);
        if (push)   count_d    = count_d + CntW'(1);
        if (pop)    count_d    = count_d - CntW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready_q <= 1'b0;
            inflight_q  <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pipe_vld_q  <= '0;
        end else begin
            // Credits cover pipeline plus FIFO, so a full FIFO can always absorb the pipeline.
            req_ready_q <= inflight_d < DepthC;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            pipe_vld_q[0] <= accept;
            for (int i = 1; i < MUX_LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        pipe_tag_q[0] <= bus.req_tag;
        pipe_err_q[0] <= addr_err;
        for (int i = 1; i < MUX_LATENCY; i++) begin
            pipe_tag_q[i] <= pipe_tag_q[i-1];
            pipe_err_q[i] <= pipe_err_q[i-1];
        end
        if (push) begin
            fifo_word_q[wr_ptr_q] <= pipe_err_q[MUX_LATENCY-1] ? '0 : mux_dout;
            fifo_tag_q[wr_ptr_q]  <= pipe_tag_q[MUX_LATENCY-1];
            fifo_err_q[wr_ptr_q]  <= pipe_err_q[MUX_LATENCY-1];
        end
    end
endmodule

// File: tb/tb_mux_fetch_ctrl.sv
// Directed bench for mux_fetch_ctrl: a 16-word and a 12-word instance, each fed by a
// behavioural pipelined MUX model, with vector tables and hand-written corner sequences.
module tb_mux_fetch_ctrl;
    localparam int unsigned DW    = 512;
    localparam int unsigned DWB   = 384;
    localparam int unsigned WW    = 32;
    localparam int unsigned AW    = 4;
    localparam int unsigned TW    = 8;
    localparam int unsigned LAT   = 3;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [WW-1:0] word;
        logic [TW-1:0] tag;
        logic          err;
    } rsp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [TW-1:0] tag;
        logic [WW-1:0] word;
        logic          err;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_fetch_if #(.DATA_WIDTH(DW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) aif ();
    mux_fetch_if #(.DATA_WIDTH(DWB), .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bif ();

    logic [DW-1:0]  a_din;
    logic [AW-1:0]  a_maddr;
    logic [WW-1:0]  a_dout;
    logic [CW-1:0]  a_infl;
    logic [DWB-1:0] b_din;
    logic [AW-1:0]  b_maddr;
    logic [WW-1:0]  b_dout;
    logic [CW-1:0]  b_infl;

    mux_fetch_ctrl #(
        .DATA_WIDTH(DW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
        .MUX_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(aif), .mux_din(a_din), .mux_addr(a_maddr),
        .mux_dout(a_dout), .inflight(a_infl)
    );

    mux_fetch_ctrl #(
        .DATA_WIDTH(DWB), .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
        .MUX_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bif), .mux_din(b_din), .mux_addr(b_maddr),
        .mux_dout(b_dout), .inflight(b_infl)
    );

    // Behavioural MUX: out-of-range addresses return junk the controller must zero.
    function automatic logic [WW-1:0] pick(input logic [DW-1:0] line, input int unsigned nwords,
                                           input logic [AW-1:0] addr);
        if (32'(addr) < nwords) return line[32'(addr)*WW +: WW];
        return 32'hDEAD_BEEF;
    endfunction

    logic [WW-1:0] a_pipe [LAT];
    logic [WW-1:0] b_pipe [LAT];
    always @(posedge clk) begin
        a_pipe[0] <= pick(a_din, DW / WW, a_maddr);
        b_pipe[0] <= pick(DW'(b_din), DWB / WW, b_maddr);
        for (int i = 1; i < LAT; i++) begin
            a_pipe[i] <= a_pipe[i-1];
            b_pipe[i] <= b_pipe[i-1];
        end
    end
    assign a_dout = a_pipe[LAT-1];
    assign b_dout = b_pipe[LAT-1];

    int   cyc = 0;
    rsp_t got_a[$];
    rsp_t got_b[$];
    int   got_cyc[$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (aif.rsp_valid && aif.rsp_ready) begin
            got_a.push_back({aif.rsp_word, aif.rsp_tag, aif.rsp_err});
            got_cyc.push_back(cyc);
        end
        if (bif.rsp_valid && bif.rsp_ready) got_b.push_back({bif.rsp_word, bif.rsp_tag, bif.rsp_err});
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    task automatic wait_a(input int n, input int budget);
        int k = 0;
        while (got_a.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic wait_b(input int n, input int budget);
        int k = 0;
        while (got_b.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        repeat (4) @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    vec_t vt2[16];
    vec_t vt5[4];
    int   acc;
    int   stale;

    initial begin
        for (int i = 0; i < 16; i++) vt2[i] = '{AW'(i), TW'(i), 32'h1000 + 32'(i), 1'b0};
        vt5[0] = '{4'd13, 8'h07, 32'h0000_0000, 1'b1};
        vt5[1] = '{4'd11, 8'h08, 32'h0000_100B, 1'b0};
        vt5[2] = '{4'd12, 8'h09, 32'h0000_0000, 1'b1};
        vt5[3] = '{4'd0,  8'h0A, 32'h0000_1000, 1'b0};

        aif.req_line = '0;
        bif.req_line = '0;
        for (int i = 0; i < 16; i++) aif.req_line[i*WW +: WW] = 32'h1000 + 32'(i);
        for (int i = 0; i < 12; i++) bif.req_line[i*WW +: WW] = 32'h1000 + 32'(i);

        // Reset with a request pending: nothing may be accepted or driven.
        rst = 1'b1;
        aif.req_valid = 1'b1;
        aif.req_addr  = 4'd5;
        aif.req_tag   = 8'h55;
        aif.rsp_ready = 1'b1;
        bif.req_valid = 1'b0;
        bif.req_addr  = '0;
        bif.req_tag   = '0;
        bif.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(aif.req_ready), 64'd0);
        check("rst_rsp_valid", 64'(aif.rsp_valid), 64'd0);
        check("rst_mux_addr", 64'(a_maddr), 64'd0);
        check("rst_inflight", 64'(a_infl), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", 64'(aif.req_ready), 64'd0);
        check("post_rst_rsp_valid", 64'(aif.rsp_valid), 64'd0);
        check("post_rst_rsp_word", 64'(aif.rsp_word), 64'd0);
        check("post_rst_rsp_tag", 64'(aif.rsp_tag), 64'd0);
        check("post_rst_rsp_err", 64'(aif.rsp_err), 64'd0);
        check("post_rst_mux_addr", 64'(a_maddr), 64'd0);
        @(posedge clk); #1 aif.req_valid = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(aif.req_ready), 64'd1);

        // Single request: response exactly LAT+1 cycles after accept, for one cycle.
        got_a.delete();
        @(posedge clk); #1 aif.req_valid = 1'b1; aif.req_addr = 4'd5; aif.req_tag = 8'h21;
        @(negedge clk);
        check("t1_accept", 64'(aif.req_ready), 64'd1);
        check("t1_mux_addr", 64'(a_maddr), 64'd5);
        check("t1_mux_din_w5", 64'(a_din[5*WW +: WW]), 64'h1005);
        @(posedge clk); #1 aif.req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("t1_valid_T+%0d", k), 64'(aif.rsp_valid), 64'(k == 4));
            if (k == 4) begin
                check("t1_word", 64'(aif.rsp_word), 64'h1005);
                check("t1_tag", 64'(aif.rsp_tag), 64'h21);
                check("t1_err", 64'(aif.rsp_err), 64'd0);
            end
        end
        check("t1_mux_addr_idle", 64'(a_maddr), 64'd0);

        // Back-to-back stream from the vector table.
        got_a.delete();
        got_cyc.delete();
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1 aif.req_valid = 1'b1; aif.req_addr = vt2[i].addr;
            aif.req_tag = vt2[i].tag;
            @(negedge clk);
            check($sformatf("t2_ready_%0d", i), 64'(aif.req_ready), 64'd1);
        end
        @(posedge clk); #1 aif.req_valid = 1'b0;
        wait_a(16, 40);
        check("t2_count", 64'(got_a.size()), 64'd16);
        for (int i = 0; i < 16 && i < got_a.size(); i++) begin
            check($sformatf("t2_word_%0d", i), 64'(got_a[i].word), 64'(vt2[i].word));
            check($sformatf("t2_tag_%0d", i), 64'(got_a[i].tag), 64'(vt2[i].tag));
            check($sformatf("t2_err_%0d", i), 64'(got_a[i].err), 64'(vt2[i].err));
            check($sformatf("t2_gap_%0d", i), 64'(got_cyc[i] - got_cyc[0]), 64'(i));
        end

        // Back-pressure: credits stop admission at exactly DEPTH.
        got_a.delete();
        aif.rsp_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1 aif.req_valid = 1'b1; aif.req_addr = AW'(acc);
            aif.req_tag = 8'h40 + TW'(acc);
            @(negedge clk);
            if (aif.req_ready) acc++;
        end
        check("t3_accepted", 64'(acc), 64'd8);
        check("t3_ready_low", 64'(aif.req_ready), 64'd0);
        check("t3_inflight", 64'(a_infl), 64'd8);
        @(posedge clk); #1 aif.req_valid = 1'b0; aif.rsp_ready = 1'b1;
        wait_a(8, 30);
        check("t3_count", 64'(got_a.size()), 64'd8);
        for (int i = 0; i < 8 && i < got_a.size(); i++) begin
            check($sformatf("t3_tag_%0d", i), 64'(got_a[i].tag), 64'h40 + 64'(i));
            check($sformatf("t3_word_%0d", i), 64'(got_a[i].word), 64'h1000 + 64'(i));
        end

        // Full FIFO, single-cycle pop with a request waiting: exactly one more admitted.
        got_a.delete();
        aif.rsp_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1 aif.req_valid = 1'b1; aif.req_addr = AW'(acc);
            aif.req_tag = 8'h60 + TW'(acc);
            @(negedge clk);
            if (aif.req_ready) acc++;
        end
        check("t4_fill", 64'(acc), 64'd8);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1 aif.rsp_ready = (c == 0); aif.req_addr = AW'(acc);
            aif.req_tag = 8'h60 + TW'(acc);
            @(negedge clk);
            if (aif.req_ready) acc++;
        end
        check("t4_accepted", 64'(acc), 64'd9);
        check("t4_inflight", 64'(a_infl), 64'd8);
        check("t4_popped", 64'(got_a.size()), 64'd1);
        @(posedge clk); #1 aif.req_valid = 1'b0; aif.rsp_ready = 1'b1;
        wait_a(9, 30);
        check("t4_count", 64'(got_a.size()), 64'd9);
        for (int i = 0; i < 9 && i < got_a.size(); i++) begin
            check($sformatf("t4_tag_%0d", i), 64'(got_a[i].tag), 64'h60 + 64'(i));
            check($sformatf("t4_word_%0d", i), 64'(got_a[i].word), 64'h1000 + 64'(i));
        end

        // 12-word line: out-of-range addresses report err with a zero word.
        got_b.delete();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 bif.req_valid = 1'b1; bif.req_addr = vt5[i].addr;
            bif.req_tag = vt5[i].tag;
            @(negedge clk);
            check($sformatf("t5_ready_%0d", i), 64'(bif.req_ready), 64'd1);
        end
        @(posedge clk); #1 bif.req_valid = 1'b0;
        wait_b(4, 30);
        check("t5_count", 64'(got_b.size()), 64'd4);
        for (int i = 0; i < 4 && i < got_b.size(); i++) begin
            check($sformatf("t5_word_%0d", i), 64'(got_b[i].word), 64'(vt5[i].word));
            check($sformatf("t5_tag_%0d", i), 64'(got_b[i].tag), 64'(vt5[i].tag));
            check($sformatf("t5_err_%0d", i), 64'(got_b[i].err), 64'(vt5[i].err));
        end

        // Reset with 4 buffered and 3 in the MUX pipeline: everything is discarded.
        got_a.delete();
        aif.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 aif.req_valid = 1'b1; aif.req_addr = AW'(i);
            aif.req_tag = 8'h80 + TW'(i);
            @(negedge clk);
            check($sformatf("t6_fill_%0d", i), 64'(aif.req_ready), 64'd1);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1 aif.req_valid = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 aif.req_valid = 1'b1; aif.req_addr = AW'(i + 4);
            aif.req_tag = 8'h90 + TW'(i);
            @(negedge clk);
            check($sformatf("t6_flight_%0d", i), 64'(aif.req_ready), 64'd1);
        end
        @(posedge clk); #1 aif.req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("t6_inflight_pre", 64'(a_infl), 64'd7);
        check("t6_rsp_valid_in_rst", 64'(aif.rsp_valid), 64'd0);
        @(posedge clk); #1 rst = 1'b0; aif.rsp_ready = 1'b1;
        @(negedge clk);
        check("t6_rsp_valid_after", 64'(aif.rsp_valid), 64'd0);
        check("t6_inflight_after", 64'(a_infl), 64'd0);
        stale = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (aif.rsp_valid) stale++;
        end
        check("t6_stale", 64'(stale), 64'd0);
        check("t6_got_none", 64'(got_a.size()), 64'd0);

        // Recovery after the mid-operation reset.
        @(posedge clk); #1 aif.req_valid = 1'b1; aif.req_addr = 4'd3; aif.req_tag = 8'hA3;
        @(negedge clk);
        check("t6_recover_ready", 64'(aif.req_ready), 64'd1);
        @(posedge clk); #1 aif.req_valid = 1'b0;
        wait_a(1, 20);
        check("t6_recover_count", 64'(got_a.size()), 64'd1);
        if (got_a.size() > 0) begin
            check("t6_recover_word", 64'(got_a[0].word), 64'h1003);
            check("t6_recover_tag", 64'(got_a[0].tag), 64'hA3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
